// File: rtl/cc_pkg.sv
// Shared cache-controller types: hit FIFO entry layout, R-burst geometry and serializer states.
package cc_pkg;

  localparam int unsigned CC_BEAT_W = 64;
  localparam int unsigned CC_LINE_W = 512;
  localparam int unsigned CC_OFS_W  = 6;
  localparam int unsigned CC_BEATS  = CC_LINE_W / CC_BEAT_W;

  typedef struct packed {
    logic [CC_OFS_W-1:0]  ofs;
    logic [CC_LINE_W-1:0] line;
  } cc_hit_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } cc_state_t;

endpackage

// File: rtl/cc_hit_data_serializer.sv
// Pops one hit entry from the hit data FIFO and replays it as an 8-beat,
// critical-word-first, wrapping R burst toward the reorder stage.
module cc_hit_data_serializer
  import cc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned LINE_WIDTH   = 512,
  parameter int unsigned OFFSET_WIDTH = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               fifo_empty_i,
  input  logic                               fifo_aempty_i,
  input  logic [LINE_WIDTH+OFFSET_WIDTH-1:0] fifo_rdata_i,
  output logic                               fifo_rden_o,
  output logic [DATA_WIDTH-1:0]              rdata_o,
  output logic                               rlast_o,
  output logic                               rvalid_o,
  input  logic                               rready_i
);

  localparam int unsigned BEATS  = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned IDX_W  = $clog2(BEATS);
  localparam int unsigned BYTE_W = $clog2(DATA_WIDTH / 8);

  cc_state_t             state_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [IDX_W-1:0]      widx_q;
  logic [IDX_W-1:0]      bcnt_q;

  cc_hit_entry_t         entry;
  logic                  hs;
  logic                  last_hs;
  logic                  load_en;
  logic [LINE_WIDTH-1:0] sel_line;
  logic [IDX_W-1:0]      sel_idx;
  logic [DATA_WIDTH-1:0] beat_d;
  logic                  unused_bits;

  assign entry       = fifo_rdata_i;
  assign unused_bits = ^{fifo_aempty_i, entry.ofs[BYTE_W-1:0]};

  assign hs      = rvalid_o && rready_i;
  assign last_hs = hs && rlast_o;
  // Gated by rst_n so nothing is popped while reset is held.
  assign load_en = rst_n && !fifo_empty_i &&
                   (state_q == IDLE || (state_q == SEND && last_hs));
  assign fifo_rden_o = load_en;

  // Registered beat source: the fresh entry on load, else the next wrapped word.
  always_comb begin
    sel_line = line_q;
    sel_idx  = widx_q + IDX_W'(1);
    if (load_en) begin
      sel_line = entry.line;
      sel_idx  = entry.ofs[BYTE_W +: IDX_W];
    end
    beat_d = sel_line[sel_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      line_q   <= '0;
      widx_q   <= '0;
      bcnt_q   <= '0;
      rvalid_o <= 1'b0;
      rlast_o  <= 1'b0;
      rdata_o  <= '0;
    end else if (load_en) begin
      state_q  <= SEND;
      line_q   <= entry.line;
      widx_q   <= entry.ofs[BYTE_W +: IDX_W];
      bcnt_q   <= '0;
      rvalid_o <= 1'b1;
      rlast_o  <= 1'b0;
      rdata_o  <= beat_d;
    end else if (last_hs) begin
      state_q  <= IDLE;
      rvalid_o <= 1'b0;
      rlast_o  <= 1'b0;
    end else if (hs) begin
      widx_q  <= widx_q + IDX_W'(1);
      bcnt_q  <= bcnt_q + IDX_W'(1);
      rdata_o <= beat_d;
      rlast_o <= (bcnt_q == IDX_W'(BEATS - 2));
    end
  end

endmodule

// File: tb/tb_cc_hit_data_serializer.sv
// Bench for the hit data serializer: FIFO model, burst scoreboard and directed scenarios.
module tb_cc_hit_data_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_empty_i;
  logic         fifo_aempty_i;
  logic [517:0] fifo_rdata_i;
  logic         fifo_rden_o;
  logic [63:0]  rdata_o;
  logic         rlast_o;
  logic         rvalid_o;
  logic         rready_i;

  cc_hit_data_serializer #(
    .DATA_WIDTH  (64),
    .LINE_WIDTH  (512),
    .OFFSET_WIDTH(6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty_i),
    .fifo_aempty_i(fifo_aempty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rden_o  (fifo_rden_o),
    .rdata_o      (rdata_o),
    .rlast_o      (rlast_o),
    .rvalid_o     (rvalid_o),
    .rready_i     (rready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  logic [517:0] fifo_q[$];
  beat_t        exp_q[$];
  beat_t        got_q[$];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned pops = 0;
  int unsigned cyc = 0;
  int unsigned vcyc = 0;
  int unsigned vfirst = 0;
  int unsigned vlast = 0;

  logic        s_rst = 1'b0;
  logic        s_hs = 1'b0;
  logic        s_rden = 1'b0;
  logic        stall_prev = 1'b0;
  logic [63:0] prev_d = '0;
  logic        prev_l = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [517:0] mk_entry(input logic [63:0] base, input logic [5:0] ofs);
    logic [511:0] line;
    for (int k = 0; k < 8; k++) line[k*64 +: 64] = base + 64'(k);
    return {ofs, line};
  endfunction

  function automatic void upd_fifo();
    fifo_empty_i  = (fifo_q.size() == 0);
    fifo_aempty_i = (fifo_q.size() <= 1);
    fifo_rdata_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  // Scoreboard: a pop schedules eight beats, critical word first, wrapping mod 8.
  always @(posedge clk) begin
    logic [517:0] e;
    #1;
    if (!s_rst) begin
      exp_q.delete();
    end else begin
      if (s_hs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (s_rden && fifo_q.size() != 0) begin
        e = fifo_q.pop_front();
        pops++;
        for (int i = 0; i < 8; i++) begin
          beat_t b;
          int w;
          w   = (int'(e[517:515]) + i) % 8;
          b.d = e[w*64 +: 64];
          b.l = (i == 7);
          exp_q.push_back(b);
        end
      end
    end
    upd_fifo();
  end

  always @(negedge clk) begin
    logic exp_rden;
    cyc++;
    exp_rden = rst_n && (fifo_q.size() != 0) &&
               (exp_q.size() == 0 || (exp_q.size() == 1 && rready_i));
    chk("rden", 64'(fifo_rden_o), 64'(exp_rden));
    if (exp_q.size() != 0) begin
      chk("rvalid", 64'(rvalid_o), 64'd1);
      chk("rdata", rdata_o, exp_q[0].d);
      chk("rlast", 64'(rlast_o), 64'(exp_q[0].l));
    end else begin
      chk("rvalid_idle", 64'(rvalid_o), 64'd0);
      chk("rlast_idle", 64'(rlast_o), 64'd0);
    end
    if (stall_prev && s_rst) begin
      chk("stall_data", rdata_o, prev_d);
      chk("stall_last", 64'(rlast_o), 64'(prev_l));
    end
    if (rvalid_o) begin
      if (vcyc == 0) vfirst = cyc;
      vlast = cyc;
      vcyc++;
    end
    stall_prev = rvalid_o && !rready_i;
    prev_d = rdata_o;
    prev_l = rlast_o;
    s_rst  = rst_n;
    s_hs   = rvalid_o && rready_i;
    s_rden = fifo_rden_o;
    if (rst_n && rvalid_o && rready_i) begin
      beat_t b;
      b.d = rdata_o;
      b.l = rlast_o;
      got_q.push_back(b);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !rvalid_o) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk({name, "_timeout"}, 64'(n), 64'(budget - 1));
  endtask

  task automatic chk_burst(input string name, input int unsigned start,
                           input logic [63:0] base, input int unsigned ord[8]);
    for (int i = 0; i < 8; i++) begin
      if (start + i < got_q.size()) begin
        chk({name, "_data"}, got_q[start+i].d, base + 64'(ord[i]));
        chk({name, "_last"}, 64'(got_q[start+i].l), 64'(i == 7));
      end else begin
        chk({name, "_missing"}, 64'(start + i), 64'(got_q.size()));
      end
    end
  endtask

  task automatic push(input logic [63:0] base, input logic [5:0] ofs);
    fifo_q.push_back(mk_entry(base, ofs));
    upd_fifo();
  endtask

  task automatic clear_stats();
    got_q.delete();
    pops = 0;
    vcyc = 0;
  endtask

  initial begin
    int unsigned n;
    rst_n    = 1'b0;
    rready_i = 1'b1;
    upd_fifo();
    repeat (3) step();
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_rlast", 64'(rlast_o), 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_rden", 64'(fifo_rden_o), 64'd0);
    rst_n = 1'b1;
    step();

    // Single entry, offset 0
    clear_stats();
    push(64'h1000, 6'h00);
    wait_idle("t1", 40);
    chk("t1_pops", 64'(pops), 64'd1);
    chk("t1_count", 64'(got_q.size()), 64'd8);
    chk("t1_vcyc", 64'(vcyc), 64'd8);
    chk_burst("t1", 0, 64'h1000, '{0, 1, 2, 3, 4, 5, 6, 7});

    // Offsets 0x3F and 0x2B
    clear_stats();
    push(64'h2000, 6'h3F);
    wait_idle("t2a", 40);
    chk_burst("t2a", 0, 64'h2000, '{7, 0, 1, 2, 3, 4, 5, 6});
    clear_stats();
    push(64'h3000, 6'h2B);
    wait_idle("t2b", 40);
    chk_burst("t2b", 0, 64'h3000, '{5, 6, 7, 0, 1, 2, 3, 4});

    // Backpressure
    clear_stats();
    push(64'h4000, 6'h12);
    rready_i = 1'b1;
    step();
    rready_i = 1'b0; step();
    step();
    n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !rvalid_o) && n < 200) begin
      rready_i = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (n >= 200) chk("t3_timeout", 64'(n), 64'd199);
    rready_i = 1'b1;
    chk("t3_count", 64'(got_q.size()), 64'd8);
    chk_burst("t3", 0, 64'h4000, '{2, 3, 4, 5, 6, 7, 0, 1});

    // Two entries back to back
    clear_stats();
    push(64'h5100, 6'h08);
    push(64'h5200, 6'h38);
    wait_idle("t4", 60);
    chk("t4_pops", 64'(pops), 64'd2);
    chk("t4_vcyc", 64'(vcyc), 64'd16);
    chk("t4_contig", 64'(vlast - vfirst + 1), 64'd16);
    chk_burst("t4a", 0, 64'h5100, '{1, 2, 3, 4, 5, 6, 7, 0});
    chk_burst("t4b", 8, 64'h5200, '{7, 0, 1, 2, 3, 4, 5, 6});

    // Permanent stall with three queued entries
    clear_stats();
    rready_i = 1'b0;
    push(64'h5000, 6'h08);
    push(64'h6100, 6'h00);
    push(64'h6200, 6'h10);
    repeat (20) step();
    chk("t5_pops", 64'(pops), 64'd1);
    chk("t5_rvalid", 64'(rvalid_o), 64'd1);
    chk("t5_hold", rdata_o, 64'h5001);
    chk("t5_fifo_left", 64'(fifo_q.size()), 64'd2);
    rready_i = 1'b1;
    wait_idle("t5", 100);
    chk("t5_count", 64'(got_q.size()), 64'd24);
    chk_burst("t5c", 16, 64'h6200, '{2, 3, 4, 5, 6, 7, 0, 1});

    // Reset mid-burst
    clear_stats();
    push(64'h6000, 6'h00);
    push(64'h7000, 6'h18);
    n = 0;
    while (got_q.size() < 3 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk("t6_timeout", 64'(n), 64'd39);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rden_in_rst", 64'(fifo_rden_o), 64'd0);
    step();
    chk("t6_rvalid", 64'(rvalid_o), 64'd0);
    chk("t6_rlast", 64'(rlast_o), 64'd0);
    chk("t6_rden", 64'(fifo_rden_o), 64'd0);
    rst_n = 1'b1;
    got_q.delete();
    wait_idle("t6", 40);
    chk("t6_pops", 64'(pops), 64'd2);
    chk("t6_count", 64'(got_q.size()), 64'd8);
    chk_burst("t6", 0, 64'h7000, '{3, 4, 5, 6, 7, 0, 1, 2});

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
